load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: XLEN, 32, data and address width; only 32 is supported.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  pipeline presents a memory request.
REQ-005 req_ready  out  1  unit can accept a request this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  in  XLEN  byte address.
REQ-009 req_wdata  in  XLEN  store data, right-aligned.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  XLEN  extended load result; 0 for stores and faults.
REQ-012 resp_misaligned  out  1  fault flag, valid with resp_valid.
REQ-013 mem_read  out  1  drives data memory MemRead.
REQ-014 mem_write  out  1  drives data memory MemWrite; write commits at the next rising edge.
REQ-015 mem_addr  out  XLEN  word-aligned address to data memory.
REQ-016 mem_wdata  out  XLEN  full word to data memory.
REQ-017 mem_rdata  in  XLEN  combinational read data from data memory, valid in the same cycle as mem_addr.

Function
REQ-018 States: IDLE, LOAD, RMW_RD, STORE, RESP. req_ready SHALL be 1 only in IDLE.
REQ-019 Accept on req_valid && req_ready; latch we, funct3, addr, wdata.
REQ-020 Fault when: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 011/110/111; store with funct3[2]=1. Transition IDLE->RESP with resp_misaligned=1, no memory access.
REQ-021 Load: IDLE->LOAD (mem_read=1); capture mem_rdata; LOAD->RESP.
REQ-022 Store W: IDLE->STORE (mem_write=1, mem_wdata=wdata); STORE->RESP.
REQ-023 Store B/H: IDLE->RMW_RD (mem_read=1); capture word; RMW_RD->STORE, writing the merged word; STORE->RESP.
REQ-024 Lane select little-endian: byte k = bits 8k+7:8k, k=addr[1:0]; half lane = addr[1].
REQ-025 B/H sign-extend; BU/HU zero-extend; merge replaces only the addressed lane(s) with the low bits of wdata.
REQ-026 mem_addr SHALL equal {addr[31:2],2'b00} in LOAD/RMW_RD/STORE, and 0 otherwise.
REQ-027 mem_read and mem_write SHALL never be high together; both are 0 in IDLE and RESP.
REQ-028 RESP lasts exactly one cycle with resp_valid=1, then IDLE. There is no response backpressure.
REQ-029 resp_rdata and resp_misaligned SHALL hold their last values until the next RESP.
REQ-030 Latency from the accept edge to the resp_valid cycle: fault 1 cycle, load 2, store W 2, store B/H 3.
REQ-031 req_valid held during busy states SHALL be ignored; it is accepted on return to IDLE.

Reset
REQ-032 rst_n low SHALL force IDLE immediately; all outputs 0 except req_ready=1; latched request cleared.
REQ-033 Reset during STORE SHALL deassert mem_write before the edge, so no write commits; the in-flight request is dropped with no response.

Structure
REQ-034 funct3 encodings and state encodings SHALL live in shared package rv_pkg, reusable by decode.
REQ-035 Lane extract/extend and merge logic SHALL be a combinational sub-module lsu_align; the FSM stays in load_store_unit.

Verification
REQ-036 SW 0xdeadbeef @0x00, then LW @0x00 -> store resp 2 cycles after accept, load resp_rdata=0xdeadbeef 2 cycles after accept.
REQ-037 With word 0xdeadbeef @0x00:
- LB @0x03 -> 0xffffffde
- LBU @0x03 -> 0x000000de
- LH @0x02 -> 0xffffdead
- LHU @0x00 -> 0x0000beef
REQ-038 SB 0x55 @0x01 over 0xdeadbeef -> mem_read cycle, then mem_write cycle; memory word 0xdead55ef; resp 3 cycles after accept.
REQ-039 LW @0x06 and SH @0x03 -> resp_misaligned=1 and resp_rdata=0 one cycle after accept; mem_read and mem_write stay 0.
REQ-040 rst_n pulsed low during the STORE cycle of SH 0x1234 @0x04 -> memory unchanged, no resp_valid, req_ready=1 immediately.
REQ-041 req_valid held high across two back-to-back LWs -> req_ready low while busy; second request accepted the cycle after the first RESP.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V memory-access encodings and LSU state encoding.
// Also used by decode, so keep it free of LSU-internal details beyond the state type.
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_LOAD,
        LSU_RMW_RD,
        LSU_STORE,
        LSU_RESP
    } lsu_state_e;

    // Misaligned halves/words, reserved widths, and unsigned store widths all fault.
    function automatic logic lsu_fault(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] byte_off);
        case (funct3)
            F3_B:    return 1'b0;
            F3_BU:   return we;
            F3_H:    return byte_off[0];
            F3_HU:   return we | byte_off[0];
            F3_W:    return byte_off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract with sign/zero extension for loads, and lane merge for sub-word stores.
// Purely combinational, no backpressure.
module lsu_align
    import rv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        byte_sh = {byte_off, 3'b000};
        half_sh = {byte_off[1], 4'b0000};
        lane_b  = mem_word[byte_sh +: 8];
        lane_h  = mem_word[half_sh +: 16];

        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'h0, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'h0, lane_h};
            default: load_data = mem_word;
        endcase

        merged_word = mem_word;
        case (funct3)
            F3_B, F3_BU: merged_word[byte_sh +: 8]  = store_data[7:0];
            F3_H, F3_HU: merged_word[half_sh +: 16] = store_data[15:0];
            default:     merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a combinational-read data memory.
// Latency accept->resp: fault 1, load 2, word store 2, byte/half store 3 (read-modify-write).
// req_ready only in IDLE; requests held while busy wait; no response backpressure.
module load_store_unit
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_misaligned,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_e      state;
    logic            lat_we;
    logic [2:0]      lat_funct3;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] merged;
    logic            accept;

    assign accept = req_valid && req_ready;

    lsu_align u_align (
        .funct3      (lat_funct3),
        .byte_off    (lat_addr[1:0]),
        .mem_word    (mem_rdata),
        .store_data  (lat_wdata),
        .load_data   (load_ext),
        .merged_word (merged)
    );

    // All outputs are registered, so an async reset drops mem_write before the commit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= LSU_IDLE;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            lat_we          <= 1'b0;
            lat_funct3      <= '0;
            lat_addr        <= '0;
            lat_wdata       <= '0;
        end else begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            case (state)
                LSU_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready  <= 1'b0;
                        lat_we     <= req_we;
                        lat_funct3 <= req_funct3;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        if (lsu_fault(req_we, req_funct3, req_addr[1:0])) begin
                            state           <= LSU_RESP;
                            resp_valid      <= 1'b1;
                            resp_misaligned <= 1'b1;
                            resp_rdata      <= '0;
                        end else if (!req_we) begin
                            state    <= LSU_LOAD;
                            mem_read <= 1'b1;
                            mem_addr <= {req_addr[XLEN-1:2], 2'b00};
                        end else if (req_funct3 == F3_W) begin
                            state     <= LSU_STORE;
                            mem_write <= 1'b1;
                            mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= LSU_RMW_RD;
                            mem_read <= 1'b1;
                            mem_addr <= {req_addr[XLEN-1:2], 2'b00};
                        end
                    end
                end
                LSU_RMW_RD: begin
                    state     <= LSU_STORE;
                    mem_write <= 1'b1;
                    mem_addr  <= {lat_addr[XLEN-1:2], 2'b00};
                    mem_wdata <= merged;
                end
                LSU_LOAD, LSU_STORE: begin
                    state           <= LSU_RESP;
                    resp_valid      <= 1'b1;
                    resp_misaligned <= 1'b0;
                    resp_rdata      <= lat_we ? '0 : load_ext;
                end
                default: begin
                    state     <= LSU_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
